// File: rtl/fetch_instruction_queue_if.sv
// Fetch/pre-decode side bundle of the fetch instruction queue.
// The queue attaches through the slave modport; fetch, decode and flush drive the master side.
interface fetch_instruction_queue_if #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int PC_WIDTH     = 32,
    parameter int INSN_WIDTH   = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                               flush;
    logic [FETCH_WIDTH-1:0]             in_valid;
    logic [FETCH_WIDTH*PC_WIDTH-1:0]    in_pc;
    logic [FETCH_WIDTH*INSN_WIDTH-1:0]  in_insn;
    logic [FETCH_WIDTH-1:0]             in_pred_taken;
    logic                               in_ready;
    logic [DECODE_WIDTH-1:0]            out_valid;
    logic [DECODE_WIDTH*PC_WIDTH-1:0]   out_pc;
    logic [DECODE_WIDTH*INSN_WIDTH-1:0] out_insn;
    logic [DECODE_WIDTH-1:0]            out_pred_taken;
    logic                               out_ready;
    logic [CNT_W-1:0]                   count;

    modport master (
        output flush, in_valid, in_pc, in_insn, in_pred_taken, out_ready,
        input  in_ready, out_valid, out_pc, out_insn, out_pred_taken, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_insn, in_pred_taken, out_ready,
        output in_ready, out_valid, out_pc, out_insn, out_pred_taken, count
    );
endinterface

// File: rtl/fetch_instruction_queue.sv
// Compacting multi-lane FIFO decoupling fetch from pre-decode, with one-cycle flush.
// Occupancy checker lives alongside the queue and is instantiated by it.
module fetch_instruction_queue_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [CNT_W-1:0] count_i
);
    // Occupancy can never exceed the storage size
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count_i <= CNT_W'(DEPTH));
endmodule

module fetch_instruction_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int PC_WIDTH     = 32,
    parameter int INSN_WIDTH   = 32
) (
    input logic                    clk,
    input logic                    rst,
    fetch_instruction_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]   mem_pc_q   [DEPTH];
    logic [INSN_WIDTH-1:0] mem_insn_q [DEPTH];
    logic                  mem_pt_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             in_ready_s;
    logic             enq_s;
    logic             deq_s;
    logic [CNT_W-1:0] n_valid_s;
    logic [CNT_W-1:0] n_in_s;
    logic [CNT_W-1:0] n_out_s;
    logic [CNT_W-1:0] avail_s;
    logic [PTR_W-1:0] slot_s   [FETCH_WIDTH];
    logic [PTR_W-1:0] rd_idx_s [DECODE_WIDTH];

    // Compaction: each valid lane's offset from tail is the number of valid lanes below it
    always_comb begin
        n_valid_s = {CNT_W{1'b0}};
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_s[i] = n_valid_s[PTR_W-1:0];
            n_valid_s = n_valid_s + CNT_W'(bus.in_valid[i]);
        end
    end

    // Accept/consume decisions use the registered count only, so dequeue never lends credit
    always_comb begin
        in_ready_s = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
        enq_s      = in_ready_s & ~bus.flush;
        deq_s      = bus.out_ready & ~bus.flush;
        avail_s    = (count_q > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : count_q;
        n_in_s     = enq_s ? n_valid_s : {CNT_W{1'b0}};
        n_out_s    = deq_s ? avail_s : {CNT_W{1'b0}};
    end

    // Pointer and occupancy next state; flush collapses everything to empty
    always_comb begin
        if (bus.flush) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            head_d  = head_q + n_out_s[PTR_W-1:0];
            tail_d  = tail_q + n_in_s[PTR_W-1:0];
            count_d = count_q + n_in_s - n_out_s;
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage is never cleared; pointers alone define what is live
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (rst && enq_s && bus.in_valid[i]) begin
                mem_pc_q[tail_q + slot_s[i]]   <= bus.in_pc[i*PC_WIDTH +: PC_WIDTH];
                mem_insn_q[tail_q + slot_s[i]] <= bus.in_insn[i*INSN_WIDTH +: INSN_WIDTH];
                mem_pt_q[tail_q + slot_s[i]]   <= bus.in_pred_taken[i];
            end
        end
    end

    // Oldest entries to pre-decode; empty lanes are forced to zero
    always_comb begin
        bus.out_valid      = {DECODE_WIDTH{1'b0}};
        bus.out_pc         = {(DECODE_WIDTH*PC_WIDTH){1'b0}};
        bus.out_insn       = {(DECODE_WIDTH*INSN_WIDTH){1'b0}};
        bus.out_pred_taken = {DECODE_WIDTH{1'b0}};
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            rd_idx_s[i] = head_q + PTR_W'(i);
            if (count_q > CNT_W'(i)) begin
                bus.out_valid[i]                        = 1'b1;
                bus.out_pc[i*PC_WIDTH +: PC_WIDTH]       = mem_pc_q[rd_idx_s[i]];
                bus.out_insn[i*INSN_WIDTH +: INSN_WIDTH] = mem_insn_q[rd_idx_s[i]];
                bus.out_pred_taken[i]                    = mem_pt_q[rd_idx_s[i]];
            end else begin
                bus.out_valid[i] = 1'b0;
            end
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.count    = count_q;

    fetch_instruction_queue_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk     (clk),
        .rst     (rst),
        .count_i (count_q)
    );
endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Bench for fetch_instruction_queue: directed vector table, stream/wrap sequence,
// then random traffic against a queue-based reference model.
module tb_fetch_instruction_queue;
    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 8;
    localparam int PCW   = 32;
    localparam int IW    = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fetch_instruction_queue_if #(
        .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PCW), .INSN_WIDTH(IW)
    ) bus ();

    fetch_instruction_queue #(
        .FETCH_WIDTH(FW), .DECODE_WIDTH(DW), .DEPTH(DEPTH), .PC_WIDTH(PCW), .INSN_WIDTH(IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [1:0]  iv;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  pt;
        logic        ordy;
        logic [3:0]  e_count;
        logic        e_ir;
        logic [1:0]  e_ov;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic [1:0]  e_pt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        pt;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];

    function automatic logic [31:0] ins(input logic [31:0] pc);
        if (pc == 32'h0000_0100) return 32'h0000_000A;
        if (pc == 32'h0000_0104) return 32'h0000_000B;
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic vec_t row(input logic rn, input logic fl, input logic [1:0] iv,
                                 input logic [31:0] p0, input logic [31:0] p1,
                                 input logic [1:0] pt, input logic ordy,
                                 input logic [3:0] ec, input logic eir, input logic [1:0] eov,
                                 input logic [31:0] ep0, input logic [31:0] ep1,
                                 input logic [1:0] ept);
        vec_t v;
        v.rst_n = rn; v.flush = fl; v.iv = iv; v.pc0 = p0; v.pc1 = p1; v.pt = pt;
        v.ordy = ordy; v.e_count = ec; v.e_ir = eir; v.e_ov = eov;
        v.e_pc0 = ep0; v.e_pc1 = ep1; v.e_pt = ept;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic rn, input logic fl, input logic [1:0] iv,
                         input logic [31:0] p0, input logic [31:0] i0,
                         input logic [31:0] p1, input logic [31:0] i1,
                         input logic [1:0] pt, input logic ordy);
        rst               = rn;
        bus.flush         = fl;
        bus.in_valid      = iv;
        bus.in_pc         = {p1, p0};
        bus.in_insn       = {i1, i0};
        bus.in_pred_taken = pt;
        bus.out_ready     = ordy;
    endtask

    // Reference model: a plain queue, updated from the rules before the edge
    task automatic tick();
        int  sz;
        bool_blk: begin
            logic ir;
            sz = mq.size();
            ir = ((DEPTH - sz) >= FW);
            if (!rst || bus.flush) begin
                mq.delete();
            end else begin
                if (bus.out_ready) begin
                    for (int k = 0; k < ((sz < DW) ? sz : DW); k++) void'(mq.pop_front());
                end
                if (ir) begin
                    for (int i = 0; i < FW; i++) begin
                        if (bus.in_valid[i]) begin
                            ent_t e;
                            e.pc   = bus.in_pc[i*PCW +: PCW];
                            e.insn = bus.in_insn[i*IW +: IW];
                            e.pt   = bus.in_pred_taken[i];
                            mq.push_back(e);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int cyc);
        int          sz;
        logic [1:0]  eov;
        logic [1:0]  ept;
        logic [63:0] epc;
        logic [63:0] einsn;
        sz = mq.size();
        eov = 2'b00; ept = 2'b00; epc = 64'd0; einsn = 64'd0;
        for (int i = 0; i < DW; i++) begin
            if (i < sz) begin
                eov[i]            = 1'b1;
                ept[i]            = mq[i].pt;
                epc[i*PCW +: PCW] = mq[i].pc;
                einsn[i*IW +: IW] = mq[i].insn;
            end
        end
        chk($sformatf("rnd%0d count", cyc), 64'(bus.count), 64'(sz));
        chk($sformatf("rnd%0d in_ready", cyc), 64'(bus.in_ready), 64'((DEPTH - sz) >= FW));
        chk($sformatf("rnd%0d out_valid", cyc), 64'(bus.out_valid), 64'(eov));
        chk($sformatf("rnd%0d out_pc", cyc), bus.out_pc, epc);
        chk($sformatf("rnd%0d out_insn", cyc), bus.out_insn, einsn);
        chk($sformatf("rnd%0d out_pt", cyc), 64'(bus.out_pred_taken), 64'(ept));
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0);

        // rst_n flush iv pc0 pc1 pt ordy | count in_ready out_valid pc0 pc1 pt
        vecs.push_back(row(1'b0, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b0, 1'b0, 2'b11, 32'h50,  32'h54,  2'b11, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h100, 32'h104, 2'b10, 1'b0, 4'd2, 1'b1, 2'b11, 32'h100, 32'h104, 2'b10));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b10, 32'h999, 32'h208, 2'b10, 1'b0, 4'd1, 1'b1, 2'b01, 32'h208, 32'h0,   2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h300, 32'h304, 2'b01, 1'b0, 4'd2, 1'b1, 2'b11, 32'h300, 32'h304, 2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h308, 32'h30C, 2'b11, 1'b0, 4'd4, 1'b1, 2'b11, 32'h300, 32'h304, 2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h310, 32'h314, 2'b00, 1'b0, 4'd6, 1'b1, 2'b11, 32'h300, 32'h304, 2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h318, 32'h31C, 2'b00, 1'b0, 4'd8, 1'b0, 2'b11, 32'h300, 32'h304, 2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h320, 32'h324, 2'b11, 1'b0, 4'd8, 1'b0, 2'b11, 32'h300, 32'h304, 2'b01));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd6, 1'b1, 2'b11, 32'h308, 32'h30C, 2'b11));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd4, 1'b1, 2'b11, 32'h310, 32'h314, 2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd2, 1'b1, 2'b11, 32'h318, 32'h31C, 2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b01, 32'h400, 32'h777, 2'b00, 1'b0, 4'd1, 1'b1, 2'b01, 32'h400, 32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h404, 32'h408, 2'b00, 1'b0, 4'd3, 1'b1, 2'b11, 32'h400, 32'h404, 2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h40C, 32'h410, 2'b00, 1'b0, 4'd5, 1'b1, 2'b11, 32'h400, 32'h404, 2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h414, 32'h418, 2'b00, 1'b0, 4'd7, 1'b0, 2'b11, 32'h400, 32'h404, 2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b11, 32'h41C, 32'h420, 2'b00, 1'b1, 4'd5, 1'b1, 2'b11, 32'h408, 32'h40C, 2'b00));
        vecs.push_back(row(1'b1, 1'b1, 2'b11, 32'h500, 32'h504, 2'b11, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));
        vecs.push_back(row(1'b1, 1'b0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b1, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0,   2'b00));

        foreach (vecs[n]) begin
            vec_t v;
            logic [31:0] ei0;
            logic [31:0] ei1;
            v   = vecs[n];
            ei0 = v.e_ov[0] ? ins(v.e_pc0) : 32'd0;
            ei1 = v.e_ov[1] ? ins(v.e_pc1) : 32'd0;
            drive(v.rst_n, v.flush, v.iv, v.pc0, ins(v.pc0), v.pc1, ins(v.pc1), v.pt, v.ordy);
            tick();
            chk($sformatf("vec%0d count", n), 64'(bus.count), 64'(v.e_count));
            chk($sformatf("vec%0d in_ready", n), 64'(bus.in_ready), 64'(v.e_ir));
            chk($sformatf("vec%0d out_valid", n), 64'(bus.out_valid), 64'(v.e_ov));
            chk($sformatf("vec%0d out_pc0", n), 64'(bus.out_pc[31:0]), 64'(v.e_pc0));
            chk($sformatf("vec%0d out_pc1", n), 64'(bus.out_pc[63:32]), 64'(v.e_pc1));
            chk($sformatf("vec%0d out_insn0", n), 64'(bus.out_insn[31:0]), 64'(ei0));
            chk($sformatf("vec%0d out_insn1", n), 64'(bus.out_insn[63:32]), 64'(ei1));
            chk($sformatf("vec%0d out_pt", n), 64'(bus.out_pred_taken), 64'(v.e_pt));
        end

        // Steady stream of 20 sequential PCs, wrapping the pointers, no bubbles
        for (int k = 0; k < 10; k++) begin
            logic [31:0] p;
            p = 32'(8 * k);
            drive(1'b1, 1'b0, 2'b11, p, ins(p), p + 32'd4, ins(p + 32'd4), 2'b00, 1'b1);
            tick();
            chk($sformatf("stream%0d out_valid", k), 64'(bus.out_valid), 64'(2'b11));
            chk($sformatf("stream%0d out_pc0", k), 64'(bus.out_pc[31:0]), 64'(p));
            chk($sformatf("stream%0d out_pc1", k), 64'(bus.out_pc[63:32]), 64'(p + 32'd4));
            chk($sformatf("stream%0d count", k), 64'(bus.count), 64'd2);
        end
        drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b1);
        tick();
        chk("stream_drain count", 64'(bus.count), 64'd0);

        // Random traffic against the reference queue
        for (int c = 0; c < 400; c++) begin
            int pct;
            pct = (c < 200) ? 70 : 30;
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), ($urandom_range(0, 99) < pct));
            tick();
            check_model(c);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_instruction_queue.md
# fetch_instruction_queue

Decoupling FIFO between the fetch stage and the pre-decode stage. Each cycle it accepts up to FETCH_WIDTH fetched instructions (PC, instruction word, predicted-taken bit), compacting away invalid lanes. It presents up to DECODE_WIDTH of the oldest entries, in program order, to pre-decode. A flush from branch recovery empties it in one cycle.

## Interface
- FETCH_WIDTH, 2: enqueue lanes per cycle.
- DECODE_WIDTH, 2: dequeue lanes per cycle.
- DEPTH, 8: entries. Power of two, ≥ FETCH_WIDTH + DECODE_WIDTH.
- PC_WIDTH, 32: PC width.
- INSN_WIDTH, 32: instruction word width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-low reset. Acts at a rising edge while 0.
- flush  in  1  discard all entries; takes priority over enqueue and dequeue.
- in_valid  in  FETCH_WIDTH  per-lane valid from fetch.
- in_pc  in  FETCH_WIDTH*PC_WIDTH  lane i at bits [i*PC_WIDTH +: PC_WIDTH].
- in_insn  in  FETCH_WIDTH*INSN_WIDTH  instruction words, same packing.
- in_pred_taken  in  FETCH_WIDTH  branch-decider taken prediction per lane.
- in_ready  out  1  queue can accept a full fetch group this cycle.
- out_valid  out  DECODE_WIDTH  thermometer code; lane i valid iff count > i.
- out_pc  out  DECODE_WIDTH*PC_WIDTH  oldest entries, lane 0 oldest.
- out_insn  out  DECODE_WIDTH*INSN_WIDTH  oldest entries.
- out_pred_taken  out  DECODE_WIDTH  oldest entries.
- out_ready  in  1  pre-decode consumes every valid out lane this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- State:
  - head and tail pointers, $clog2(DEPTH) bits each, wrap modulo DEPTH.
  - count register.
  - DEPTH-entry storage of {pc, insn, pred_taken}.
- in_ready = (DEPTH − count ≥ FETCH_WIDTH). It is derived only from the registered count; same-cycle dequeue gives no credit.
- Enqueue:
  - Occurs when in_ready=1 and flush=0.
  - n_in = popcount(in_valid).
  - Valid lanes are written in ascending lane order to tail, tail+1, …; invalid lanes are skipped (compaction). Example: in_valid=2'b10 writes lane 1 at tail.
  - tail += n_in.
  - When in_ready=0, inputs are ignored. Fetch must hold the group.
- Dequeue:
  - n_out = popcount(out_valid) = min(count, DECODE_WIDTH).
  - When out_ready=1 and flush=0: head += n_out.
  - Partial consumption is not supported.
- count_next = count + n_in − n_out. Simultaneous enqueue and dequeue are legal, including at full/empty boundaries.
- Output data:
  - out lane i reads entry (head+i) mod DEPTH.
  - Data is combinational from storage.
  - Lanes with out_valid[i]=0 drive all-zero pc/insn/pred_taken.
- Flush:
  - head, tail and count go to 0 at the next edge.
  - In the flush cycle, in_valid and out_ready are ignored: nothing is written, nothing is consumed.
  - Outputs in the flush cycle still reflect the pre-flush contents. Downstream must ignore them, since it receives the same flush.
- Reset (rst=0 at an edge): same effect as flush. Storage contents are not cleared.
- Reset values: count=0, in_ready=1, out_valid=0, out_pc=0, out_insn=0, out_pred_taken=0.
- Overflow cannot occur by construction. A simulation assertion fires if count > DEPTH.

## Timing
- Enqueue-to-visible latency: 1 cycle. A group accepted at edge N appears on out_* after edge N.
- No combinational path from in_* to out_*.
- No combinational path from out_ready to in_ready.
- out_valid, in_ready and count depend only on registers.
- Sustained throughput: min(FETCH_WIDTH, DECODE_WIDTH) per cycle with no bubbles, provided count + FETCH_WIDTH ≤ DEPTH.
- Full condition: in_ready=0 when count > DEPTH − FETCH_WIDTH (count > 6 at default parameters). This holds even if dequeue happens the same cycle.
- Wrap-around: pointers roll from DEPTH−1 to 0 without any stall cycle.

## Test plan
- Reset with rst=0 for 2 cycles, then release → count=0, in_ready=1, out_valid=2'b00, all out data 0.
- Enqueue {pc 0x100 insn 0xA, pc 0x104 insn 0xB} with out_ready=0 → next cycle out_valid=2'b11, out_pc lane0=0x100, lane1=0x104, count=2.
- in_valid=2'b10 with pc lane1=0x208 into an empty queue → out_valid=2'b01, out_pc lane0=0x208, count=1.
- Fill with out_ready=0 over 4 groups → count stops at 8. in_ready=0 from count=7 onward, and the 5th group is not accepted. Then out_ready=1 for 4 cycles → FIFO order preserved, count=0.
- Steady stream of 20 sequential PCs 0x0, 0x4, … with out_ready=1 throughout → in-order output across pointer wrap, count stays ≤ 2, no bubbles after the first cycle.
- count=5, then flush=1 together with in_valid=2'b11 and out_ready=1 → next cycle count=0, out_valid=0. The flushed-cycle group never appears.
